// File: rtl/tik_sched.sv
// tik_sched: global tik scheduler with minimum period, step counting and overrun flag.
// Define TIK_SCHED_EXT_SYNC_EN to add the ext_sync lockstep input gating GAP->TIK_HI.
module tik_sched #(
   parameter int NODE_NUM = 4,
   parameter int PW       = 16,
   parameter int TW       = 16,
   parameter int TIK_HIGH = 4,
   parameter int SETTLE   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_stop,
   input  logic [PW-1:0]       cfg_period,
   input  logic [TW-1:0]       cfg_steps,
   input  logic [NODE_NUM-1:0] node_busy,
   input  logic                overrun_clr,
`ifdef TIK_SCHED_EXT_SYNC_EN
   input  logic                ext_sync,
`endif
   output logic                tik,
   output logic                running,
   output logic [TW-1:0]       step_cnt,
   output logic                done,
   output logic                overrun
);
   localparam int PH_MAX = TIK_HIGH > SETTLE ? TIK_HIGH : SETTLE;
   localparam int CW     = $clog2(PH_MAX + 1);
   typedef enum logic [2:0] {S_IDLE, S_TIK, S_SETTLE, S_WAIT, S_GAP} state_t;
   state_t        state, state_n;
   logic [CW-1:0] ph_cnt;
   logic [PW-1:0] per_cnt, period_l, per_last;
   logic [TW-1:0] steps_l;
   logic          stop_req, ext_ok, any_busy, last_step, wait_exit, tik_rise;
   assign any_busy  = |node_busy;
   assign per_last  = period_l - 1'b1;
   assign last_step = (steps_l != '0 && TW'(step_cnt + 1'b1) == steps_l) || stop_req;
   assign wait_exit = state == S_WAIT && !any_busy;
   assign tik_rise  = state != S_TIK && state_n == S_TIK;
`ifdef TIK_SCHED_EXT_SYNC_EN
   // seen_q only survives while parked in GAP, so earlier edges are forgotten
   logic [2:0] sync_q;
   logic       seen_q, sync_rise;
   assign sync_rise = sync_q[1] & ~sync_q[2];
   assign ext_ok    = seen_q | sync_rise;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_q <= '0;
         seen_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], ext_sync};
         seen_q <= state == S_GAP && ext_ok;
      end
`else
   assign ext_ok = 1'b1;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   state_n = cfg_start && !cfg_stop ? S_TIK : S_IDLE;
         S_TIK:    state_n = ph_cnt == CW'(TIK_HIGH - 1) ? S_SETTLE : S_TIK;
         S_SETTLE: state_n = ph_cnt == CW'(SETTLE - 1) ? S_WAIT : S_SETTLE;
         S_WAIT:   state_n = any_busy ? S_WAIT : last_step ? S_IDLE : S_GAP;
         S_GAP:    state_n = (period_l == '0 || per_cnt >= per_last) && ext_ok ? S_TIK : S_GAP;
         default:  state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tik      <= 1'b0;
         running  <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         step_cnt <= '0;
         ph_cnt   <= '0;
         per_cnt  <= '0;
         period_l <= '0;
         steps_l  <= '0;
         stop_req <= 1'b0;
      end else begin
         tik      <= state_n == S_TIK;
         running  <= state_n != S_IDLE;
         done     <= wait_exit && last_step;
         ph_cnt   <= state_n == state && (state == S_TIK || state == S_SETTLE) ? ph_cnt + 1'b1 : '0;
         per_cnt  <= tik_rise ? '0 : state != S_IDLE && !(&per_cnt) ? per_cnt + 1'b1 : per_cnt;
         stop_req <= state_n == S_IDLE ? 1'b0 : stop_req | (cfg_stop & state != S_IDLE);
         overrun  <= (state == S_WAIT && any_busy && period_l != '0 && per_cnt == per_last)
                     || (overrun && !overrun_clr);
         if (state == S_IDLE && tik_rise) begin
            period_l <= cfg_period;
            steps_l  <= cfg_steps;
            step_cnt <= '0;
         end else if (wait_exit) begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
endmodule

// File: tb/tb_tik_sched.sv
// tb_tik_sched: vector table, corner sequences and randomized runs against a timing model of tik_sched.
module tb_tik_sched;
   logic        clk = 1'b0, rst = 1'b1, cfg_start = 1'b0, cfg_stop = 1'b0, overrun_clr = 1'b0;
   logic [15:0] cfg_period = '0, cfg_steps = '0;
   logic [3:0]  node_busy = '0;
   logic        tik, running, done, overrun;
   logic [15:0] step_cnt;
`ifdef TIK_SCHED_EXT_SYNC_EN
   logic        ext_sync = 1'b0;
`endif
   int errs = 0, checks = 0;
   int nr, hi_tot, done_t, done_cnt;
   int rise[16];
   bit ovh[400];
   typedef struct {int p, n, b, sp, dt; bit ov;} vec_t;
   vec_t tbl[8];
   always #5 clk = ~clk;
   tik_sched dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_period(cfg_period), .cfg_steps(cfg_steps), .node_busy(node_busy),
      .overrun_clr(overrun_clr),
`ifdef TIK_SCHED_EXT_SYNC_EN
      .ext_sync(ext_sync),
`endif
      .tik(tik), .running(running), .step_cnt(step_cnt), .done(done), .overrun(overrun)
   );
   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic idle_inputs();
      cfg_start = 0; cfg_stop = 0; overrun_clr = 0; node_busy = '0;
   endtask
   // nodes react to the observed tik: busy for b cycles starting 8 cycles after the rise
   task automatic run_r(input int p, input int n, input int b, input int stop_at, input int clr_to, input int st2_at);
      int  lr;
      logic pt;
      nr = 0; hi_tot = 0; done_t = -1; done_cnt = 0; lr = 0; pt = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (tik && !pt) begin
            if (nr < 16) rise[nr] = t;
            nr++;
            lr = t;
         end
         pt = tik;
         if (tik) hi_tot++;
         if (done) begin done_cnt++; done_t = t; end
         ovh[t] = overrun;
         if (done_cnt > 0 && t > done_t + 2) break;
         cfg_start   = t == 0 || t == st2_at;
         cfg_period  = t == 0 ? 16'(p) : 16'd3;
         cfg_steps   = t == 0 ? 16'(n) : 16'd7;
         cfg_stop    = t == stop_at;
         overrun_clr = t <= clr_to;
         node_busy   = nr > 0 && t >= lr + 8 && t < lr + 8 + b ? 4'b0110 : 4'b0000;
      end
      idle_inputs();
   endtask
   // model: rise k+1 = rise k + max(TIK_HIGH+SETTLE+2+busy, period); exit at rise+8+busy
   task automatic run_model(input int p, input int n);
      int   r[4], e[4], bl[4], last, se;
      bit   ov[4];
      logic te, re, de, oe;
      r[0] = 1;
      for (int k = 0; k < n; k++) begin
         bl[k] = $urandom_range(0, 12);
         e[k]  = r[k] + 8 + bl[k];
         ov[k] = p >= 9 && p <= 8 + bl[k];
         if (k < n - 1) r[k+1] = r[k] + (10 + bl[k] > p ? 10 + bl[k] : p);
      end
      last = e[n-1];
      for (int t = 0; t <= last + 3; t++) begin
         @(negedge clk);
         te = 0; re = t >= 1 && t <= last; de = t == last + 1; oe = 0; se = 0;
         for (int k = 0; k < n; k++) begin
            te = te | (t >= r[k] && t <= r[k] + 3);
            if (e[k] < t) se++;
            if (ov[k] && t >= r[k] + p) oe = 1;
         end
         if (t > 0) chk("rand_run", {tik, running, done, overrun, step_cnt}, {te, re, de, oe, 16'(se)});
         cfg_start   = t == 0 || (t >= 2 && t <= last && $urandom_range(0, 15) == 0);
         overrun_clr = t == 0;
         cfg_period  = t == 0 ? 16'(p) : 16'($urandom);
         cfg_steps   = t == 0 ? 16'(n) : 16'($urandom);
         node_busy   = '0;
         for (int k = 0; k < n; k++)
            if (t >= r[k] + 5 && t <= r[k] + 7 + bl[k]) node_busy = 4'($urandom_range(1, 15));
      end
      idle_inputs();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      int cnt;
      tbl[0] = '{20, 3, 0, 20, 50, 1'b0};
      tbl[1] = '{0, 2, 0, 10, 20, 1'b0};
      tbl[2] = '{12, 2, 30, 40, 80, 1'b1};
      tbl[3] = '{9, 1, 0, 0, 10, 1'b0};
      tbl[4] = '{9, 1, 1, 0, 11, 1'b1};
      tbl[5] = '{8, 1, 5, 0, 15, 1'b0};
      tbl[6] = '{15, 2, 0, 15, 25, 1'b0};
      tbl[7] = '{10, 2, 0, 10, 20, 1'b0};
      repeat (2) @(negedge clk);
      chk("reset_outputs", {tik, running, done, overrun, step_cnt}, 0);
      rst = 0;
`ifdef TIK_SCHED_EXT_SYNC_EN
      begin
         logic pt;
         nr = 0; pt = 0;
         for (int t = 0; t <= 260; t++) begin
            @(negedge clk);
            if (tik && !pt) begin
               if (nr < 16) rise[nr] = t;
               nr++;
            end
            pt = tik;
            cfg_start = t == 0; cfg_period = '0; cfg_steps = '0;
            ext_sync = (t % 50) < 25;
         end
         cfg_start = 0;
         chk("ext_tik_count", nr, 6);
         chk("ext_first_sync_tik", rise[1], 53);
         for (int i = 2; i < 6; i++) chk("ext_spacing", rise[i] - rise[i-1], 50);
         ext_sync = 0; cnt = 0;
         repeat (60) begin @(negedge clk); if (tik) cnt++; end
         chk("ext_parked_no_tik", cnt, 0);
         chk("ext_parked_running", running, 1);
         rst = 1; @(negedge clk); rst = 0;
      end
`else
      foreach (tbl[i]) begin
         run_r(tbl[i].p, tbl[i].n, tbl[i].b, -1, 0, -1);
         chk("tik_count", nr, tbl[i].n);
         chk("first_rise", rise[0], 1);
         if (tbl[i].n > 1) chk("tik_spacing", rise[1] - rise[0], tbl[i].sp);
         chk("done_cycle", done_t, tbl[i].dt);
         chk("done_pulses", done_cnt, 1);
         chk("overrun", overrun, tbl[i].ov);
         chk("step_cnt", step_cnt, tbl[i].n);
         chk("running_end", running, 0);
         chk("tik_high_total", hi_tot, 4 * tbl[i].n);
      end
      run_r(0, 0, 6, 18, 0, -1);
      chk("stop_tiks", nr, 2);
      chk("stop_tik_high", hi_tot, 8);
      chk("stop_done", done_t, 32);
      chk("stop_done_pulses", done_cnt, 1);
      chk("stop_step_cnt", step_cnt, 2);
      @(negedge clk); cfg_start = 1; cfg_stop = 1; cnt = 0;
      repeat (15) begin @(negedge clk); idle_inputs(); if (tik || running) cnt++; end
      chk("start_stop_idle", cnt, 0);
      run_r(12, 1, 30, -1, 12, 5);
      chk("clr_held", ovh[12], 0);
      chk("set_wins_over_clr", ovh[13], 1);
      chk("start_ignored_done", done_t, 40);
      chk("start_ignored_tiks", nr, 1);
      chk("overrun_sticky", overrun, 1);
      @(negedge clk); overrun_clr = 1;
      @(negedge clk); overrun_clr = 0;
      chk("overrun_clr", overrun, 0);
      repeat (12) run_model($urandom_range(0, 30), $urandom_range(1, 4));
      @(negedge clk); cfg_period = 16'd12; cfg_steps = '0; cfg_start = 1;
      for (int t = 1; t <= 30; t++) begin
         @(negedge clk);
         cfg_start = 0;
         node_busy = t >= 15 ? 4'hF : 4'h0;
      end
      chk("pre_rst_wait", {tik, running, done, overrun, step_cnt}, {4'b0101, 16'd1});
      #2 rst = 1;
      #1 chk("rst_mid_wait", {tik, running, done, overrun, step_cnt}, 0);
      @(negedge clk); rst = 0; node_busy = '0; cnt = 0;
      repeat (20) begin @(negedge clk); if (tik || running) cnt++; end
      chk("no_tik_after_rst", cnt, 0);
      cfg_start = 1;
      @(negedge clk); cfg_start = 0;
      @(negedge clk); chk("tik_before_rst", tik, 1);
      #2 rst = 1;
      #1 chk("rst_mid_tik", {tik, running, done, overrun, step_cnt}, 0);
      @(negedge clk); rst = 0; cnt = 0;
      repeat (20) begin @(negedge clk); if (tik || running) cnt++; end
      chk("no_tik_after_rst2", cnt, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
